// File: rtl/peripheral_ahb4_slave_mem.sv
// ---------------------------------------------------------------------------
// peripheral_ahb4_slave_mem
//
// AHB4 slave that fronts a small 64-bit-wide memory of MEM_DEPTH words.
// Transfers are single beats; bursts are treated as independent beats.
// An illegal transfer gets the two-cycle ERROR response. A write commits its
// byte lanes on the edge that ends its data phase. A read returns the whole
// 64-bit word in its completing cycle.
//
// Optional feature: define PERIPHERAL_AHB4_WAIT_EN to insert WAIT_STATES
// data-phase wait cycles on every non-error transfer. Without the macro every
// non-error transfer is zero-wait.
//
// Ports
//   HRESETn    in   asynchronous active-low reset
//   HCLK       in   clock, rising edge
//   HSEL       in   slave select
//   HADDR      in   byte address
//   HWDATA     in   write data (data phase)
//   HRDATA     out  read data, zero outside a read completion cycle
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size (bytes = 2**HSIZE)
//   HBURST     in   burst type, ignored
//   HPROT      in   protection, ignored
//   HTRANS     in   transfer type
//   HMASTLOCK  in   ignored
//   HREADY     in   bus ready
//   HREADYOUT  out  slave ready
//   HRESP      out  0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module peripheral_ahb4_slave_mem #(
  parameter int HADDR_SIZE  = 64,
  parameter int HDATA_SIZE  = 64,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                    IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [HADDR_SIZE-1:0] MEM_BYTES = HADDR_SIZE'(MEM_DEPTH * 8);

`ifdef PERIPHERAL_AHB4_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'b00, ERR1 = 2'b01, ERR2 = 2'b10, WAIT = 2'b11} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'b00, ERR1 = 2'b01, ERR2 = 2'b10} state_t;
`endif

  state_t                  state;
  logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];

  // Data-phase context of the accepted transfer
  logic                    d_active;
  logic                    d_write;
  logic [IDX_W-1:0]        d_idx;
  logic [2:0]              d_off;
  logic [1:0]              d_size;

  logic                    accept;
  logic                    a_err;
  logic [IDX_W-1:0]        a_idx;
  logic                    wr_commit;
  logic [HDATA_SIZE-1:0]   wr_word;
  logic [HDATA_SIZE-1:0]   rd_word;

`ifdef PERIPHERAL_AHB4_WAIT_EN
  logic [3:0]              cnt;
`else
  logic [3:0]              unused_wait_states;
  assign unused_wait_states = 4'(WAIT_STATES);
`endif

  logic                    unused_ctrl;
  assign unused_ctrl = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Replace the 2**sz byte lanes starting at off with the new data.
  function automatic logic [HDATA_SIZE-1:0] lane_merge(
    input logic [HDATA_SIZE-1:0] old_w,
    input logic [HDATA_SIZE-1:0] new_w,
    input logic [2:0]            off,
    input logic [1:0]            sz
  );
    logic [7:0]            be;
    logic [HDATA_SIZE-1:0] res;
    case (sz)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0f;
      default: be = 8'hff;
    endcase
    be  = be << off;
    res = old_w;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Oversized, misaligned or out-of-range transfers are answered with ERROR.
  function automatic logic xfer_error(
    input logic [HADDR_SIZE-1:0] addr,
    input logic [2:0]            sz
  );
    logic misal;
    case (sz)
      3'd0:    misal = 1'b0;
      3'd1:    misal = addr[0];
      3'd2:    misal = |addr[1:0];
      3'd3:    misal = |addr[2:0];
      default: misal = 1'b1;
    endcase
    return misal || (addr >= MEM_BYTES);
  endfunction

  // HREADYOUT is high only in states able to take a new address phase.
  assign accept    = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign a_err     = xfer_error(HADDR, HSIZE);
  assign a_idx     = HADDR[IDX_W+2:3];

  // IDLE with a live data phase is the completion cycle.
  assign wr_commit = (state == IDLE) && d_active && d_write;
  assign wr_word   = lane_merge(mem[d_idx], HWDATA, d_off, d_size);
  // A read accepted while a write to the same word completes sees the merged word.
  assign rd_word   = (wr_commit && (d_idx == a_idx)) ? wr_word : mem[a_idx];

  // Address phase -> data phase context
  always_ff @(posedge HCLK) begin
    if (accept) begin
      d_write <= HWRITE;
      d_idx   <= a_idx;
      d_off   <= HADDR[2:0];
      d_size  <= HSIZE[1:0];
    end
  end

  // Data phase end -> memory commit
  always_ff @(posedge HCLK) begin
    if (wr_commit) mem[d_idx] <= wr_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      d_active  <= 1'b0;
`ifdef PERIPHERAL_AHB4_WAIT_EN
      cnt       <= '0;
`endif
    end else begin
      HRDATA <= '0;
      case (state)
        IDLE, ERR2: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          d_active  <= 1'b0;
          if (accept) begin
            if (a_err) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end
`ifdef PERIPHERAL_AHB4_WAIT_EN
            else if (WAIT_STATES != 0) begin
              state     <= WAIT;
              HREADYOUT <= 1'b0;
              d_active  <= 1'b1;
              cnt       <= 4'(WAIT_STATES);
            end
`endif
            else begin
              d_active <= 1'b1;
              if (!HWRITE) HRDATA <= rd_word;
            end
          end
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
`ifdef PERIPHERAL_AHB4_WAIT_EN
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            if (!d_write) HRDATA <= mem[d_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          d_active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_ahb4_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_peripheral_ahb4_slave_mem
//
// Directed bench for peripheral_ahb4_slave_mem (MEM_DEPTH=16, WAIT_STATES=2).
// Requests are queued and issued back-to-back; a prediction for each request
// is pushed to a scoreboard when its address phase is driven, and popped and
// compared when the slave completes the data phase. Works with or without
// PERIPHERAL_AHB4_WAIT_EN defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_peripheral_ahb4_slave_mem;

  localparam int WS = 2;
`ifdef PERIPHERAL_AHB4_WAIT_EN
  localparam int EXP_WAITS = WS;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel;
  logic [63:0] haddr;
  logic [63:0] hwdata;
  logic [63:0] hrdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hready;
  logic        hreadyout;
  logic        hresp;

  assign hready = hreadyout;

  always #5 clk = ~clk;

  peripheral_ahb4_slave_mem #(
    .HADDR_SIZE (64),
    .HDATA_SIZE (64),
    .MEM_DEPTH  (16),
    .WAIT_STATES(WS)
  ) dut (
    .HRESETn  (rst_n),
    .HCLK     (clk),
    .HSEL     (hsel),
    .HADDR    (haddr),
    .HWDATA   (hwdata),
    .HRDATA   (hrdata),
    .HWRITE   (hwrite),
    .HSIZE    (hsize),
    .HBURST   (hburst),
    .HPROT    (hprot),
    .HTRANS   (htrans),
    .HMASTLOCK(hmastlock),
    .HREADY   (hready),
    .HREADYOUT(hreadyout),
    .HRESP    (hresp)
  );

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    int          id;
    logic        err;
    logic        wr;
    logic [63:0] rdata;
    logic [63:0] wdata;
    int          waits;
  } exp_t;

  req_t        reqq[$];
  exp_t        expq[$];
  logic [63:0] mdl [16];
  int          checks   = 0;
  int          failures = 0;
  int          seq      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] addr, input logic wr, input logic [2:0] size,
                      input logic [63:0] wdata);
    req_t r;
    r.addr = addr; r.wr = wr; r.size = size; r.wdata = wdata;
    reqq.push_back(r);
  endtask

  // Reference model: legality check plus byte-lane memory update.
  function automatic exp_t predict(input req_t r, input int id);
    exp_t e;
    int   idx;
    int   off;
    int   nb;
    nb    = 1;
    e.id  = id;
    e.wr  = r.wr;
    e.wdata = r.wdata;
    e.rdata = '0;
    e.err = 1'b0;
    if (r.size > 3'd3) e.err = 1'b1;
    else begin
      nb = 1 << r.size;
      if ((r.addr % 64'(nb)) != 64'd0) e.err = 1'b1;
    end
    if (r.addr >= 64'd128) e.err = 1'b1;
    e.waits = e.err ? 1 : EXP_WAITS;
    if (!e.err) begin
      idx = int'(r.addr[6:3]);
      off = int'(r.addr[2:0]);
      if (r.wr) begin
        for (int b = off; b < off + nb; b++) mdl[idx][8*b +: 8] = r.wdata[8*b +: 8];
      end else begin
        e.rdata = mdl[idx];
      end
    end
    return e;
  endfunction

  // Issues queued requests pipelined; entered and left at posedge+1.
  task automatic run_queue();
    int   guard;
    int   lowc;
    req_t r;
    exp_t cur;
    guard = 0;
    lowc  = 0;
    while ((reqq.size() != 0 || expq.size() != 0) && guard < 400) begin
      if (expq.size() != 0) begin
        cur = expq[0];
        if (cur.wr) hwdata = cur.wdata;
        if (!hreadyout) begin
          chk($sformatf("lowcyc_resp_%0d", cur.id), {63'd0, hresp}, {63'd0, cur.err});
          chk($sformatf("lowcyc_rdata_%0d", cur.id), hrdata, 64'd0);
          lowc++;
        end else begin
          chk($sformatf("resp_%0d", cur.id), {63'd0, hresp}, {63'd0, cur.err});
          chk($sformatf("waits_%0d", cur.id), 64'(lowc), 64'(cur.waits));
          chk($sformatf("rdata_%0d", cur.id), hrdata, (cur.wr || cur.err) ? 64'd0 : cur.rdata);
          cur  = expq.pop_front();
          lowc = 0;
        end
      end
      hsel   = 1'b0;
      htrans = 2'b00;
      if (hreadyout && reqq.size() != 0) begin
        r      = reqq.pop_front();
        htrans = (expq.size() != 0) ? 2'b11 : 2'b10;
        hsel   = 1'b1;
        haddr  = r.addr;
        hwrite = r.wr;
        hsize  = r.size;
        hburst = 3'($urandom_range(0, 7));
        hprot  = 4'($urandom_range(0, 15));
        hmastlock = 1'($urandom_range(0, 1));
        expq.push_back(predict(r, seq));
        seq++;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("queue_timeout", {63'd0, guard >= 400}, 64'd0);
    reqq.delete();
    expq.delete();
  endtask

  initial begin
    hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = '0;
    hburst = '0; hprot = '0; htrans = 2'b00; hmastlock = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hreadyout", {63'd0, hreadyout}, 64'd1);
    chk("reset_hresp", {63'd0, hresp}, 64'd0);
    chk("reset_hrdata", hrdata, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read back (pipelined, forwarded when zero-wait)
    push(64'h08, 1'b1, 3'd3, 64'h1122334455667788);
    push(64'h08, 1'b0, 3'd3, 64'd0);
    run_queue();

    // Byte write into lane 3
    push(64'h0B, 1'b1, 3'd0, 64'h00000000_AA000000);
    push(64'h08, 1'b0, 3'd3, 64'd0);
    run_queue();
    chk("byte_merge_model", mdl[1], 64'h11223344AA667788);

    // Out-of-range read, misaligned word write, oversized transfer
    push(64'h00, 1'b1, 3'd3, 64'h0123456789ABCDEF);
    push(64'h80, 1'b0, 3'd3, 64'd0);
    push(64'h06, 1'b1, 3'd2, 64'hFFFFFFFF_FFFFFFFF);
    push(64'h00, 1'b0, 3'd3, 64'd0);
    push(64'h00, 1'b0, 3'd4, 64'd0);
    push(64'h08, 1'b0, 3'd3, 64'd0);
    run_queue();

    // Back-to-back write/read of the same word
    push(64'h10, 1'b1, 3'd3, 64'hCAFEF00D12345678);
    push(64'h10, 1'b0, 3'd3, 64'd0);
    push(64'h12, 1'b1, 3'd1, 64'h00000000_BEEF0000);
    push(64'h10, 1'b0, 3'd3, 64'd0);
    run_queue();

    // Top word of the array, word and byte sized accesses
    push(64'h78, 1'b1, 3'd3, 64'h8877665544332211);
    push(64'h7C, 1'b1, 3'd2, 64'hDEADBEEF_00000000);
    push(64'h7F, 1'b0, 3'd0, 64'd0);
    push(64'h7A, 1'b0, 3'd1, 64'd0);
    run_queue();

    // IDLE and BUSY transfers: zero-wait OKAY, no data
    hsel = 1'b1; htrans = 2'b00; haddr = 64'h08; hwrite = 1'b0; hsize = 3'd3;
    @(posedge clk); #1;
    chk("idle_hreadyout", {63'd0, hreadyout}, 64'd1);
    chk("idle_hresp", {63'd0, hresp}, 64'd0);
    chk("idle_hrdata", hrdata, 64'd0);
    htrans = 2'b01; haddr = 64'h80;
    @(posedge clk); #1;
    chk("busy_hreadyout", {63'd0, hreadyout}, 64'd1);
    chk("busy_hresp", {63'd0, hresp}, 64'd0);
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;

    // Reset during the data phase of a write abandons it
    push(64'h18, 1'b1, 3'd3, 64'h5A5A5A5A_A5A5A5A5);
    run_queue();
    hsel = 1'b1; htrans = 2'b10; haddr = 64'h18; hwrite = 1'b1; hsize = 3'd3;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 64'h0F0F0F0F_0F0F0F0F;
    chk("abort_first_cycle_ready", {63'd0, hreadyout}, (EXP_WAITS > 0) ? 64'd0 : 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hreadyout", {63'd0, hreadyout}, 64'd1);
    chk("abort_hresp", {63'd0, hresp}, 64'd0);
    chk("abort_hrdata", hrdata, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    push(64'h18, 1'b0, 3'd3, 64'd0);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
